// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: shares the register-file write port between the ALU path (req0)
// and the load/multicycle path (req1). Optional `WB_CONFLICT_CNT_EN adds a conflict counter.
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              wb_sel,
`ifdef WB_CONFLICT_CNT_EN
    output logic [15:0]       conflict_cnt,
`endif
    output logic              conflict
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]        starve_q, starve_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              sel_q, sel_d;
    logic              grant0, grant1;

    // req1 wins when alone, or when it has lost STARVE_MAX conflicts in a row.
    always_comb begin
        grant1 = req1_valid && (!req0_valid || (starve_q == STARVE_LIM));
        grant0 = req0_valid && !grant1;
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign conflict   = req0_valid && req1_valid;

    always_comb begin
        starve_d = starve_q;
        we_d     = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        sel_d    = sel_q;
        if (grant1) begin
            starve_d = 4'd0;
            waddr_d  = req1_addr;
            wdata_d  = req1_data;
            sel_d    = 1'b1;
            we_d     = (req1_addr != '0);
        end else if (grant0) begin
            if (conflict && (starve_q < STARVE_LIM))
                starve_d = starve_q + 4'd1;
            waddr_d = req0_addr;
            wdata_d = req0_data;
            sel_d   = 1'b0;
            we_d    = (req0_addr != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= 4'd0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            sel_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            sel_q    <= sel_d;
        end
    end

    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign wb_sel   = sel_q;

`ifdef WB_CONFLICT_CNT_EN
    logic [15:0] ccnt_q, ccnt_d;

    always_comb begin
        ccnt_d = ccnt_q;
        if (conflict && (ccnt_q != 16'hFFFF))
            ccnt_d = ccnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ccnt_q <= 16'd0;
        else        ccnt_q <= ccnt_d;
    end

    assign conflict_cnt = ccnt_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, reset/starvation sequences,
// and random traffic against a rule-level reference model.
module tb_wb_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SMAX = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready, rf_we, wb_sel, conflict;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
`ifdef WB_CONFLICT_CNT_EN
    logic [15:0]   conflict_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int m_ccnt = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .wb_sel(wb_sel),
`ifdef WB_CONFLICT_CNT_EN
        .conflict_cnt(conflict_cnt),
`endif
        .conflict(conflict)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    // Advance one edge; sample registered outputs 1 time unit later.
    task automatic edge_step();
        if (req0_valid && req1_valid && m_ccnt < 65535) m_ccnt++;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic v0; logic [AW-1:0] a0; logic [DW-1:0] d0;
        logic v1; logic [AW-1:0] a1; logic [DW-1:0] d1;
        logic rdy0; logic rdy1; logic conf;
        logic we; logic [AW-1:0] wa; logic [DW-1:0] wd; logic sel;
    } vec_t;

    vec_t tbl[12];

    // Reference model state: losses req1 has suffered since it last won.
    int            m_loss;
    logic          m_we, m_sel;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;

    initial begin
        int winner;
        logic p0, p1;
        logic          v0, v1;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;

        tbl[0]  = '{1, 8, 32'h1234_5678, 0, 0, 0,              1, 0, 0, 1, 8,  32'h1234_5678, 0};
        tbl[1]  = '{0, 0, 0,             0, 0, 0,              0, 0, 0, 0, 8,  32'h1234_5678, 0};
        tbl[2]  = '{0, 0, 0,             1, 31, 32'hDEAD_BEEF, 0, 1, 0, 1, 31, 32'hDEAD_BEEF, 1};
        tbl[3]  = '{0, 0, 0,             1, 0, 32'hFFFF_FFFF,  0, 1, 0, 0, 0,  32'hFFFF_FFFF, 1};
        tbl[4]  = '{1, 1, 32'hA1,        1, 2, 32'hB2,         1, 0, 1, 1, 1,  32'hA1,        0};
        tbl[5]  = '{1, 3, 32'hA3,        1, 2, 32'hB2,         1, 0, 1, 1, 3,  32'hA3,        0};
        tbl[6]  = '{1, 4, 32'hA4,        0, 0, 0,              1, 0, 0, 1, 4,  32'hA4,        0};
        tbl[7]  = '{1, 5, 32'hA5,        1, 2, 32'hB2,         1, 0, 1, 1, 5,  32'hA5,        0};
        tbl[8]  = '{1, 6, 32'hA6,        1, 2, 32'hB2,         0, 1, 1, 1, 2,  32'hB2,        1};
        tbl[9]  = '{1, 6, 32'hA6,        1, 7, 32'hB7,         1, 0, 1, 1, 6,  32'hA6,        0};
        tbl[10] = '{0, 0, 0,             1, 7, 32'hB7,         0, 1, 0, 1, 7,  32'hB7,        1};
        tbl[11] = '{1, 0, 32'hC0,        1, 9, 32'hB9,         1, 0, 1, 0, 0,  32'hC0,        0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_sel", wb_sel, 0);
        rst_n = 1'b1;
        m_ccnt = 0;

        // Directed table
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
            #1;
            chk($sformatf("t%0d_rdy0", i), req0_ready, tbl[i].rdy0);
            chk($sformatf("t%0d_rdy1", i), req1_ready, tbl[i].rdy1);
            chk($sformatf("t%0d_conf", i), conflict, tbl[i].conf);
            edge_step();
            chk($sformatf("t%0d_we", i), rf_we, tbl[i].we);
            chk($sformatf("t%0d_waddr", i), rf_waddr, tbl[i].wa);
            chk($sformatf("t%0d_wdata", i), rf_wdata, tbl[i].wd);
            chk($sformatf("t%0d_sel", i), wb_sel, tbl[i].sel);
        end

        // Reset asserted mid-cycle with both requesters valid
        drive(1, 5'd11, 32'h5555, 1, 5'd12, 32'h6666);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mrst_we", rf_we, 0);
        chk("mrst_waddr", rf_waddr, 0);
        chk("mrst_wdata", rf_wdata, 0);
        chk("mrst_sel", wb_sel, 0);
        @(posedge clk);
        #1;
        chk("mrst_we_held", rf_we, 0);
        chk("mrst_waddr_held", rf_waddr, 0);
        rst_n = 1'b1;
        m_ccnt = 0;

        // Continuous conflict: req1 wins every (SMAX+1)th cycle
        for (int c = 0; c < 12; c++) begin
            logic exp1;
            exp1 = ((c % (SMAX + 1)) == SMAX);
            #1;
            chk($sformatf("stv%0d_conf", c), conflict, 1);
            chk($sformatf("stv%0d_rdy0", c), req0_ready, !exp1);
            chk($sformatf("stv%0d_rdy1", c), req1_ready, exp1);
            edge_step();
            chk($sformatf("stv%0d_sel", c), wb_sel, exp1);
            chk($sformatf("stv%0d_waddr", c), rf_waddr, exp1 ? 5'd12 : 5'd11);
        end

        // Random traffic against the rule-level model, starting from a fresh reset
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_ccnt = 0;
        m_loss = 0; m_we = 0; m_sel = 0; m_wa = '0; m_wd = '0;
        p0 = 0; p1 = 0;
        v0 = 0; v1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int c = 0; c < 2000; c++) begin
            if (!p0) begin
                v0 = ($urandom_range(0, 3) != 0);
                a0 = AW'($urandom_range(0, 31)); d0 = $urandom;
            end
            if (!p1) begin
                v1 = ($urandom_range(0, 2) == 0);
                a1 = AW'($urandom_range(0, 31)); d1 = $urandom;
            end
            drive(v0, a0, d0, v1, a1, d1);
            // Winner from the grant rules: -1 none, 0 req0, 1 req1
            if (v0 && v1) winner = (m_loss >= SMAX) ? 1 : 0;
            else if (v1)  winner = 1;
            else if (v0)  winner = 0;
            else          winner = -1;
            #1;
            chk("rnd_conf", conflict, v0 && v1);
            chk("rnd_rdy0", req0_ready, winner == 0);
            chk("rnd_rdy1", req1_ready, winner == 1);
            if (winner == 1) m_loss = 0;
            else if (winner == 0 && v1) m_loss = m_loss + 1;
            m_we = 0;
            if (winner == 0) begin m_we = (a0 != 0); m_wa = a0; m_wd = d0; m_sel = 0; end
            if (winner == 1) begin m_we = (a1 != 0); m_wa = a1; m_wd = d1; m_sel = 1; end
            p0 = v0 && (winner != 0);
            p1 = v1 && (winner != 1);
            edge_step();
            chk("rnd_we", rf_we, m_we);
            chk("rnd_waddr", rf_waddr, m_wa);
            chk("rnd_wdata", rf_wdata, m_wd);
            chk("rnd_sel", wb_sel, m_sel);
`ifdef WB_CONFLICT_CNT_EN
            chk("rnd_ccnt", conflict_cnt, m_ccnt);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
